// File: rtl/alu_sequencer_if.sv
// Request/response handshakes and the ALU operand/select/bus wires of the sequencer.
// Both handshakes: a transfer happens on a rising edge where valid && ready are both high.
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_t;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_t;
  logic [3:0]       alu_sel;
  logic             alu_e;
  logic [WIDTH-1:0] alu_bus;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_sign;
  logic             rsp_err;

  logic             busy;

  // Control unit and ALU side.
  modport master (
    output req_valid, req_op, req_a, req_t, rsp_ready, alu_bus, alu_carry,
    input  req_ready, alu_a, alu_t, alu_sel, alu_e,
    input  rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_sign, rsp_err, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_t, rsp_ready, alu_bus, alu_carry,
    output req_ready, alu_a, alu_t, alu_sel, alu_e,
    output rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_sign, rsp_err, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Runs one SAP-II ALU operation per request: latch operands, let the ALU settle,
// enable its bus for one cycle, capture result and flags, hold them until accepted.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr_n,
  alu_sequencer_if.slave       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, RESP} state_t;

  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_LAST = 4'hB;

  state_t state;

  // Ready is gated by clr_n so nothing is accepted while reset is held.
  assign bus.req_ready = (state == IDLE) && clr_n;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      bus.alu_a     <= '0;
      bus.alu_t     <= '0;
      bus.alu_sel   <= '0;
      bus.alu_e     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_zero  <= 1'b1;
      bus.rsp_sign  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.alu_a   <= bus.req_a;
            bus.alu_t   <= bus.req_t;
            bus.alu_sel <= bus.req_op;
            if (bus.req_op <= OP_LAST) begin
              state <= SETUP;
            end else begin
              // Illegal opcode: answer immediately, the ALU is never enabled.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_zero  <= 1'b1;
              bus.rsp_carry <= 1'b0;
              bus.rsp_sign  <= 1'b0;
            end
          end
        end
        SETUP: begin
          state     <= DRIVE;
          bus.alu_e <= 1'b1;
        end
        DRIVE: begin
          state         <= RESP;
          bus.alu_e     <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= bus.alu_bus;
          bus.rsp_zero  <= (bus.alu_bus == '0);
          bus.rsp_sign  <= bus.alu_bus[WIDTH-1];
          // The ALU carry output is only meaningful for ADD/SUB.
          bus.rsp_carry <= ((bus.alu_sel == OP_ADD) || (bus.alu_sel == OP_SUB))
                           ? bus.alu_carry : 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencer that owns the SAP-II ALU and runs one operation per request. Each request is an opcode plus two operands, accepted over a valid/ready handshake. The block drives the ALU's operand inputs, select lines (S4..S1) and bus enable, samples the ALU result from the shared bus, and returns result plus flags over a second valid/ready handshake. It sits between the control unit and the ALU. It is the only agent allowed to assert the ALU bus enable.

## Interface
- WIDTH, 8, datapath width; must match the ALU.

- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state==IDLE) && clr_n.
- req_op  in  4  ALU opcode ({S4,S3,S2,S1} encoding): 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 NOT A, 6 INC A, 7 DEC A, 8 ROL A, 9 ROR A, A INC T, B DEC T; C–F illegal.
- req_a  in  WIDTH  operand A.
- req_t  in  WIDTH  operand T.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_t  out  WIDTH  registered operand T to the ALU.
- alu_sel  out  4  registered {S4,S3,S2,S1}.
- alu_e  out  1  ALU bus enable; high only in DRIVE.
- alu_bus  in  WIDTH  ALU out_bus.
- alu_carry  in  1  ALU carry output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  result.
- rsp_carry  out  1  carry/borrow. Equals alu_carry for ops 3 and 4; 0 for all other ops.
- rsp_zero  out  1  rsp_data == 0.
- rsp_sign  out  1  rsp_data[WIDTH-1].
- rsp_err  out  1  illegal opcode.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, SETUP, DRIVE, RESP.
- IDLE:
  - On req_valid && req_ready, register req_a, req_t and req_op into alu_a, alu_t and alu_sel.
  - If the opcode is legal (0–B), go to SETUP.
  - If the opcode is illegal (C–F), go to RESP with rsp_err=1, rsp_data=0, rsp_zero=1 and the other flags 0. The ALU is never enabled for an illegal opcode.
- SETUP: one cycle with alu_e=0 so ALU combinational outputs settle. Always goes to DRIVE.
- DRIVE: one cycle with alu_e=1. At the closing edge:
  - capture alu_bus into rsp_data and compute the flags;
  - capture alu_carry for ops 3 and 4 only;
  - go to RESP.
- RESP:
  - rsp_valid=1; the rsp_* payload is held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE and clear rsp_valid.
- Arithmetic belongs entirely to the ALU; the block does not recompute results.
  - ADD and SUB carry is bit WIDTH of the (WIDTH+1)-bit result.
  - For SUB this is the borrow.
- alu_a, alu_t and alu_sel hold their values until the next accepted request. They do not return to 0 after an operation.
- Request fields are ignored whenever req_ready=0.

## Timing
- Reset values while clr_n=0, applied asynchronously:
  - state=IDLE;
  - alu_a, alu_t, alu_sel = 0;
  - alu_e, rsp_valid, rsp_err, rsp_carry, rsp_sign = 0;
  - rsp_data = 0 and rsp_zero = 1;
  - busy = 0 and req_ready = 0.
- After clr_n deasserts, req_ready=1 immediately, because the FSM is in IDLE.
- Legal op accepted at edge k: SETUP in cycle k..k+1, DRIVE in k+1..k+2, rsp_valid high from edge k+2. Accept-to-response latency is 2 cycles.
- Illegal op accepted at edge k: rsp_valid high from edge k. Latency is 0 extra cycles; rsp_valid is seen in the next cycle.
- req_ready returns the cycle after the response handshake. Peak throughput is one legal op per 4 cycles when rsp_ready is held high.
- alu_e is high for exactly one cycle per legal op and never in any other state. This prevents bus contention.
- Reset asserted mid-operation, including during DRIVE:
  - the operation is abandoned;
  - alu_e and rsp_valid drop immediately;
  - no response is produced.

## Test plan
- ADD, A=0x3C, T=0x35 -> rsp_data=0x71, carry=0, zero=0, sign=0; rsp_valid 2 cycles after acceptance; alu_e high exactly 1 cycle.
- ADD, A=0xF0, T=0x20 -> rsp_data=0x10, carry=1. Then SUB, A=0x1C, T=0x75 -> rsp_data=0xA7, carry=1, sign=1.
- ROL (op 8), A=0x81 -> rsp_data=0x03, carry=0. Then XOR, A=0x55, T=0x55 -> rsp_data=0x00, zero=1.
- Illegal op 0xD -> rsp_err=1, rsp_data=0 on the cycle after acceptance; alu_e never asserted; next request accepted normally.
- rsp_ready held low for 5 cycles in RESP -> payload stable, req_ready=0, busy=1; handshake on cycle 6 returns to IDLE and req_ready=1 on the next cycle.
- clr_n pulsed low during DRIVE -> alu_e, rsp_valid and busy go to 0 without waiting for clk; no response is emitted; a fresh INC T (op A, T=0xFF) after reset -> rsp_data=0x00, zero=1, carry=0.
